// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler feeding a DEPTH-stage tagged pipeline; latency DEPTH cycles per word, plus one per stall cycle.
// Backpressure: out_ready=0 stalls the whole pipe (or only full stages when PIPE_RR_SCHED_BUBBLE_EN is defined).
// Flush drops every in-flight word; reset also clears the round-robin pointer and payload registers.
module pipe_rr_sched #(
    parameter  int NREQ  = 4,
    parameter  int DW    = 4,
    parameter  int DEPTH = 3,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [IDW-1:0]     out_id,
    input  logic               out_ready,
    output logic               busy
);

    logic [IDW-1:0]   ptr;
    logic [DEPTH-1:0] stg_vld;
    logic [DW-1:0]    stg_dat [DEPTH];
    logic [IDW-1:0]   stg_id  [DEPTH];

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [DW-1:0]    gnt_dat;
    logic             gnt_found;
    logic [DEPTH-1:0] adv;
    logic             load;
    logic             xfer;

    logic [DEPTH-1:0] in_vld;
    logic [DW-1:0]    in_dat [DEPTH];
    logic [IDW-1:0]   in_id  [DEPTH];

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int j;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_dat   = '0;
        gnt_found = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!gnt_found && req_valid[j]) begin
                gnt[j]    = 1'b1;
                gnt_idx   = IDW'(j);
                gnt_dat   = req_data[j*DW +: DW];
                gnt_found = 1'b1;
            end
        end
    end

`ifdef PIPE_RR_SCHED_BUBBLE_EN
    // A stage moves when it is empty or its successor moves, so holes close up under a stalled output.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = ~stg_vld[DEPTH-1] | out_ready;
        adv[DEPTH-1] = chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            chain  = ~stg_vld[k] | chain;
            adv[k] = chain;
        end
    end
`else
    assign adv = {DEPTH{~stg_vld[DEPTH-1] | out_ready}};
`endif

    assign load      = adv[0];
    assign xfer      = gnt_found & load & ~flush & ~rst;
    assign req_ready = gnt & {NREQ{load & ~flush & ~rst}};

    always_comb begin
        in_vld    = '0;
        in_vld[0] = xfer;
        in_dat[0] = gnt_dat;
        in_id[0]  = gnt_idx;
        for (int k = 1; k < DEPTH; k++) begin
            in_vld[k] = stg_vld[k-1];
            in_dat[k] = stg_dat[k-1];
            in_id[k]  = stg_id[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= '0;
            ptr     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stg_dat[k] <= '0;
                stg_id[k]  <= '0;
            end
        end else if (flush) begin
            stg_vld <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k]) begin
                    stg_vld[k] <= in_vld[k];
                    // Bubbles leave the payload untouched so the output data only changes on real words.
                    if (in_vld[k]) begin
                        stg_dat[k] <= in_dat[k];
                        stg_id[k]  <= in_id[k];
                    end
                end
            end
            if (xfer) ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    assign out_valid = stg_vld[DEPTH-1];
    assign out_data  = stg_dat[DEPTH-1];
    assign out_id    = stg_id[DEPTH-1];
    assign busy      = |stg_vld;

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Bench for pipe_rr_sched (NREQ=4, DW=4, DEPTH=3): vector table for arbitration and latency, hand sequences for stall/flush/reset.
module tb_pipe_rr_sched;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;

    pipe_rr_sched #(.NREQ(4), .DW(4), .DEPTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] d;
    } item_t;

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] rd;
        logic [3:0]  rdy;
        logic        ov;
        logic [3:0]  od;
        logic [1:0]  oid;
        logic        busy;
    } vec_t;

    item_t q[$];
    item_t sb_exp;
    item_t sb_new;
    vec_t  vec[18];
    int    p;

`ifdef PIPE_RR_SCHED_BUBBLE_EN
    localparam bit BUBBLE = 1'b1;
`else
    localparam bit BUBBLE = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] rv, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        req_valid = rv;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Scoreboard: words are pushed on accept and popped when the consumer takes them.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_extra: got id %0d data %0h expected no word", out_id, out_data);
                end else begin
                    sb_exp = q.pop_front();
                    chk("sb_id", 32'(out_id), 32'(sb_exp.id));
                    chk("sb_data", 32'(out_data), 32'(sb_exp.d));
                end
            end
            if (flush) q.delete();
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_new.id = 2'(i);
                    sb_new.d  = req_data[i*4 +: 4];
                    q.push_back(sb_new);
                end
            end
            chk("onehot", 32'($countones(req_ready) <= 1), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;

        //            rv     rd        rdy   ov    od    oid   busy
        vec[0]  = '{4'hF, 16'h4321, 4'h1, 1'b0, 4'h0, 2'd0, 1'b0};
        vec[1]  = '{4'hF, 16'h4321, 4'h2, 1'b0, 4'h0, 2'd0, 1'b1};
        vec[2]  = '{4'hF, 16'h4321, 4'h4, 1'b0, 4'h0, 2'd0, 1'b1};
        vec[3]  = '{4'hF, 16'h4321, 4'h8, 1'b1, 4'h1, 2'd0, 1'b1};
        vec[4]  = '{4'hF, 16'h4321, 4'h1, 1'b1, 4'h2, 2'd1, 1'b1};
        vec[5]  = '{4'hF, 16'h4321, 4'h2, 1'b1, 4'h3, 2'd2, 1'b1};
        vec[6]  = '{4'hF, 16'h4321, 4'h4, 1'b1, 4'h4, 2'd3, 1'b1};
        vec[7]  = '{4'hF, 16'h4321, 4'h8, 1'b1, 4'h1, 2'd0, 1'b1};
        vec[8]  = '{4'h4, 16'h0A00, 4'h4, 1'b1, 4'h2, 2'd1, 1'b1};
        vec[9]  = '{4'h0, 16'h0A00, 4'h0, 1'b1, 4'h3, 2'd2, 1'b1};
        vec[10] = '{4'h0, 16'h0A00, 4'h0, 1'b1, 4'h4, 2'd3, 1'b1};
        vec[11] = '{4'hF, 16'h4321, 4'h8, 1'b1, 4'hA, 2'd2, 1'b1};
        vec[12] = '{4'hF, 16'h4321, 4'h1, 1'b0, 4'hA, 2'd2, 1'b1};
        vec[13] = '{4'hF, 16'h4321, 4'h2, 1'b0, 4'hA, 2'd2, 1'b1};
        vec[14] = '{4'h0, 16'h4321, 4'h0, 1'b1, 4'h4, 2'd3, 1'b1};
        vec[15] = '{4'h0, 16'h4321, 4'h0, 1'b1, 4'h1, 2'd0, 1'b1};
        vec[16] = '{4'h0, 16'h4321, 4'h0, 1'b1, 4'h2, 2'd1, 1'b1};
        vec[17] = '{4'h0, 16'h4321, 4'h0, 1'b0, 4'h2, 2'd1, 1'b0};

        // Reset state
        @(posedge clk); #1; req_valid = 4'hF; #1;
        chk("rst_rdy", 32'(req_ready), 32'h0);
        @(posedge clk); #1; rst = 1'b0; req_valid = 4'h0; #1;
        chk("rst_ov", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_od", 32'(out_data), 32'h0);
        chk("rst_oid", 32'(out_id), 32'h0);

        // Round-robin order, single-requester grant, latency, bubble payload retention
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            req_valid = vec[i].rv;
            req_data  = vec[i].rd;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(req_ready), 32'(vec[i].rdy));
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vec[i].ov));
            chk($sformatf("v%0d_od", i), 32'(out_data), 32'(vec[i].od));
            chk($sformatf("v%0d_oid", i), 32'(out_id), 32'(vec[i].oid));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].busy));
        end

        // Full pipeline stalled for 5 cycles, then released
        p = 2;
        for (int c = 0; c < 3; c++) begin
            step(4'hF, 1'b1, 1'b0);
            chk("fill_rdy", 32'(req_ready), 32'(1 << p));
            p = (p + 1) % 4;
        end
        for (int c = 0; c < 5; c++) begin
            step(4'hF, 1'b0, 1'b0);
            chk("stall_rdy", 32'(req_ready), 32'h0);
            chk("stall_ov", 32'(out_valid), 32'h1);
            chk("stall_oid", 32'(out_id), 32'h2);
            chk("stall_od", 32'(out_data), 32'h3);
        end
        step(4'h0, 1'b1, 1'b0);
        chk("rel0_oid", 32'(out_id), 32'h2);
        step(4'h0, 1'b1, 1'b0);
        chk("rel1_oid", 32'(out_id), 32'h3);
        step(4'h0, 1'b1, 1'b0);
        chk("rel2_oid", 32'(out_id), 32'h0);
        step(4'h0, 1'b1, 1'b0);
        chk("rel_busy", 32'(busy), 32'h0);

        // One word in flight with a stalled output; empty stages fill only in the bubble build
        step(4'hF, 1'b0, 1'b0);
        chk("inf_rdy", 32'(req_ready), 32'(1 << p));
        p = (p + 1) % 4;
        step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            step(4'hF, 1'b0, 1'b0);
            chk("inf_ov", 32'(out_valid), 32'h1);
            if (BUBBLE) begin
                chk("inf_fill_rdy", 32'(req_ready), 32'(1 << p));
                p = (p + 1) % 4;
            end else begin
                chk("inf_hold_rdy", 32'(req_ready), 32'h0);
            end
        end
        for (int c = 0; c < 2; c++) begin
            step(4'hF, 1'b0, 1'b0);
            chk("inf_full_rdy", 32'(req_ready), 32'h0);
            chk("inf_oid", 32'(out_id), 32'h1);
        end
        for (int c = 0; c < 5; c++) step(4'h0, 1'b1, 1'b0);
        chk("inf_busy", 32'(busy), 32'h0);

        // Flush with three words in flight
        for (int c = 0; c < 3; c++) begin
            step(4'hF, 1'b1, 1'b0);
            chk("fl_fill_rdy", 32'(req_ready), 32'(1 << p));
            p = (p + 1) % 4;
        end
        step(4'hF, 1'b1, 1'b1);
        chk("fl_rdy", 32'(req_ready), 32'h0);
        chk("fl_busy", 32'(busy), 32'h1);
        step(4'h0, 1'b1, 1'b0);
        chk("fl_after_busy", 32'(busy), 32'h0);
        chk("fl_after_ov", 32'(out_valid), 32'h0);
        for (int c = 0; c < 2; c++) begin
            step(4'hF, 1'b1, 1'b0);
            chk("fl_ptr_rdy", 32'(req_ready), 32'(1 << p));
            p = (p + 1) % 4;
        end

        // Reset mid-stream together with flush
        @(posedge clk); #1; rst = 1'b1; flush = 1'b1; req_valid = 4'hF; #1;
        chk("mrst_rdy", 32'(req_ready), 32'h0);
        @(posedge clk); #1; rst = 1'b0; flush = 1'b0; req_valid = 4'b0110; #1;
        chk("mrst_ov", 32'(out_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_od", 32'(out_data), 32'h0);
        chk("mrst_oid", 32'(out_id), 32'h0);
        chk("mrst_rdy1", 32'(req_ready), 32'h2);
        step(4'h0, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        chk("mrst_out_ov", 32'(out_valid), 32'h1);
        chk("mrst_out_oid", 32'(out_id), 32'h1);
        chk("mrst_out_od", 32'(out_data), 32'h2);
        step(4'h0, 1'b1, 1'b0);
        chk("end_busy", 32'(busy), 32'h0);
        chk("end_sb_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
